// File: rtl/phase_scheduler.sv
// phase_scheduler: round-robin actuated green/yellow/all-red/walk sequencer; PHASE_SCHED_FLASH_EN adds a night flashing mode
module phase_scheduler #(
    parameter int N_APPR      = 4,
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 40,
    parameter int T_YELLOW    = 4,
    parameter int T_ALL_RED   = 2,
    parameter int T_PED       = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_APPR-1:0]     req,
    input  logic                  ped_bt,
`ifdef PHASE_SCHED_FLASH_EN
    input  logic                  night_mode,
`endif
    output logic [3*N_APPR-1:0]   lights,
    output logic                  ped_walk,
    output logic [2:0]            active_idx,
    output logic                  phase_start
);
    localparam logic [CNT_W-1:0] MIN_G = CNT_W'(T_MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_G = CNT_W'(T_MAX_GREEN);
    localparam logic [CNT_W-1:0] YEL_T = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] AR_T  = CNT_W'(T_ALL_RED);
    localparam logic [CNT_W-1:0] PED_T = CNT_W'(T_PED);

`ifdef PHASE_SCHED_FLASH_EN
    typedef enum logic [2:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_PED_WALK, S_FLASH} state_t;
`else
    typedef enum logic [2:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_PED_WALK} state_t;
`endif

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           last_grant, idx_nxt, pick;
    logic                 ped_pending, ped_served, ped_prev, ped_rise, discard;
    logic                 demand_other, enter, flash_wrap;
    logic [N_APPR-1:0]    act_oh;
    logic [3*N_APPR-1:0]  lights_nxt;
    int                   best;

    assign ped_rise     = ped_bt & ~ped_prev;
    assign act_oh       = {{(N_APPR-1){1'b0}}, 1'b1} << active_idx;
    assign demand_other = |(req & ~act_oh) | ped_pending;
    assign enter        = state_nxt != state;

`ifdef PHASE_SCHED_FLASH_EN
    logic flash_on, flash_nxt;
    assign discard    = (state == S_PED_WALK) || (state == S_FLASH);
    assign flash_wrap = (state == S_FLASH) && (cnt >= YEL_T);
    assign flash_nxt  = (state != S_FLASH) ? 1'b1 : flash_wrap ? ~flash_on : flash_on;
`else
    assign discard    = state == S_PED_WALK;
    assign flash_wrap = 1'b0;
`endif

    // Nearest requester after last_grant, measured as circular distance
    always_comb begin
        best = N_APPR;
        pick = last_grant;
        for (int j = 0; j < N_APPR; j++)
            if (req[j] && ((j + 2*N_APPR - int'(last_grant) - 1) % N_APPR) < best) begin
                best = (j + 2*N_APPR - int'(last_grant) - 1) % N_APPR;
                pick = 3'(j);
            end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = active_idx;
        case (state)
            S_ALL_RED:
                if (cnt >= AR_T) begin
`ifdef PHASE_SCHED_FLASH_EN
                    if (night_mode) state_nxt = S_FLASH; else
`endif
                    if (ped_pending && !(ped_served && |req)) state_nxt = S_PED_WALK;
                    else if (|req) begin
                        state_nxt = S_GREEN;
                        idx_nxt   = pick;
                    end
                end
            S_GREEN:
                if (cnt >= MIN_G && demand_other && (!(|(req & act_oh)) || cnt >= MAX_G))
                    state_nxt = S_YELLOW;
            S_YELLOW:   state_nxt = (cnt >= YEL_T) ? S_ALL_RED : S_YELLOW;
            S_PED_WALK: state_nxt = (cnt >= PED_T) ? S_ALL_RED : S_PED_WALK;
`ifdef PHASE_SCHED_FLASH_EN
            S_FLASH:    state_nxt = night_mode ? S_FLASH : S_ALL_RED;
`endif
            default:    state_nxt = S_ALL_RED;
        endcase
    end

    // Lamp codes are decoded from the next state so they register in step with it
    always_comb begin
        lights_nxt = '0;
        for (int i = 0; i < N_APPR; i++) begin
            lights_nxt[3*i +: 3] = (state_nxt == S_GREEN  && idx_nxt == 3'(i)) ? 3'b100 :
                                   (state_nxt == S_YELLOW && idx_nxt == 3'(i)) ? 3'b010 : 3'b001;
`ifdef PHASE_SCHED_FLASH_EN
            if (state_nxt == S_FLASH) lights_nxt[3*i +: 3] = flash_nxt ? 3'b010 : 3'b000;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_ALL_RED;
            cnt         <= CNT_W'(1);
            active_idx  <= 3'd0;
            last_grant  <= 3'(N_APPR-1);
            ped_pending <= 1'b0;
            ped_served  <= 1'b0;
            ped_prev    <= 1'b0;
            lights      <= {N_APPR{3'b001}};
            ped_walk    <= 1'b0;
            phase_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= (enter || flash_wrap) ? CNT_W'(1) : (&cnt) ? cnt : cnt + CNT_W'(1);
            active_idx  <= idx_nxt;
            last_grant  <= (enter && state_nxt == S_GREEN) ? idx_nxt : last_grant;
            ped_prev    <= ped_bt;
            ped_pending <= (enter && state_nxt == S_PED_WALK) ? 1'b0 :
                           (ped_rise && !discard) ? 1'b1 : ped_pending;
            ped_served  <= (enter && state_nxt == S_PED_WALK) ? 1'b1 :
                           (enter && state_nxt == S_GREEN) ? 1'b0 : ped_served;
            lights      <= lights_nxt;
            ped_walk    <= state_nxt == S_PED_WALK;
            phase_start <= enter;
        end
    end

`ifdef PHASE_SCHED_FLASH_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flash_on <= 1'b1;
        else      flash_on <= flash_nxt;
    end
`endif
endmodule
